// File: rtl/i8088_bus_pkg.sv
`default_nettype none
// ============================================================================
// i8088_bus_pkg : shared types and default region map for the 8088 bus front end
// Revision 1.0
// ============================================================================
package i8088_bus_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, XFER} bus_state_t;
  typedef enum logic [1:0] {NONE, MEM0, MEM1, IO} region_t;

  localparam int          c_CNT_W     = $clog2(8);
  localparam logic [19:0] c_MEM0_BASE = 20'h00000;
  localparam logic [19:0] c_MEM0_SIZE = 20'h80000;
  localparam logic [19:0] c_MEM1_BASE = 20'h80000;
  localparam logic [19:0] c_MEM1_SIZE = 20'h80000;
  localparam logic [15:0] c_IO_BASE   = 16'hFF00;
  localparam logic [15:0] c_IO_SIZE   = 16'h0010;

endpackage
`default_nettype wire

// File: rtl/bus_addr_decoder.sv
`default_nettype none
// ============================================================================
// bus_addr_decoder : combinational address/IOM to region decode
// Revision 1.0
// ============================================================================
module bus_addr_decoder
  import i8088_bus_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 20,
  parameter logic [ADDR_WIDTH-1:0] MEM0_BASE  = c_MEM0_BASE,
  parameter logic [ADDR_WIDTH-1:0] MEM0_SIZE  = c_MEM0_SIZE,
  parameter logic [ADDR_WIDTH-1:0] MEM1_BASE  = c_MEM1_BASE,
  parameter logic [ADDR_WIDTH-1:0] MEM1_SIZE  = c_MEM1_SIZE,
  parameter logic [15:0]           IO_BASE    = c_IO_BASE,
  parameter logic [15:0]           IO_SIZE    = c_IO_SIZE
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_iom,
  output region_t               o_region
);

  // Offsets carry one extra bit so an address below base shows up as a borrow
  logic [ADDR_WIDTH:0] w_mem0_off;
  logic [ADDR_WIDTH:0] w_mem1_off;
  logic [16:0]         w_io_off;
  logic                w_mem0_hit;
  logic                w_mem1_hit;
  logic                w_io_hit;

  assign w_mem0_off = {1'b0, i_addr} - {1'b0, MEM0_BASE};
  assign w_mem1_off = {1'b0, i_addr} - {1'b0, MEM1_BASE};
  assign w_io_off   = {1'b0, i_addr[15:0]} - {1'b0, IO_BASE};

  assign w_mem0_hit = !w_mem0_off[ADDR_WIDTH] && (w_mem0_off[ADDR_WIDTH-1:0] < MEM0_SIZE);
  assign w_mem1_hit = !w_mem1_off[ADDR_WIDTH] && (w_mem1_off[ADDR_WIDTH-1:0] < MEM1_SIZE);
  assign w_io_hit   = !w_io_off[16] && (w_io_off[15:0] < IO_SIZE);

  always_comb begin
    o_region = NONE;
    if (i_iom) begin
      if (w_io_hit) o_region = IO;
    end else if (w_mem0_hit) begin
      o_region = MEM0;
    end else if (w_mem1_hit) begin
      o_region = MEM1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/i8088_bus_interface.sv
`default_nettype none
// ============================================================================
// i8088_bus_interface : 8088 local bus demux, region decode, wait states, data steering
// Revision 1.0
// ============================================================================
module i8088_bus_interface
  import i8088_bus_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 20,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] MEM0_BASE  = c_MEM0_BASE,
  parameter logic [ADDR_WIDTH-1:0] MEM0_SIZE  = c_MEM0_SIZE,
  parameter logic [ADDR_WIDTH-1:0] MEM1_BASE  = c_MEM1_BASE,
  parameter logic [ADDR_WIDTH-1:0] MEM1_SIZE  = c_MEM1_SIZE,
  parameter logic [15:0]           IO_BASE    = c_IO_BASE,
  parameter logic [15:0]           IO_SIZE    = c_IO_SIZE,
  parameter int unsigned           MEM_WAIT   = 0,
  parameter int unsigned           IO_WAIT    = 2
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic                             ALE,
  inout  wire  [DATA_WIDTH-1:0]            AD,
  input  logic [ADDR_WIDTH-DATA_WIDTH-1:0] A_HI,
  input  logic                             IOM,
  input  logic                             RD_n,
  input  logic                             WR_n,
  output logic                             READY,
  output logic [ADDR_WIDTH-1:0]            Address,
  output logic                             CS_MEM0,
  output logic                             CS_MEM1,
  output logic                             CS_IO,
  output logic                             OE,
  output logic                             WR,
  inout  wire  [DATA_WIDTH-1:0]            Data,
  output logic                             BUS_ERR
);

  localparam logic [c_CNT_W-1:0] c_MEM_WAIT = c_CNT_W'(MEM_WAIT);
  localparam logic [c_CNT_W-1:0] c_IO_WAIT  = c_CNT_W'(IO_WAIT);

  bus_state_t              r_state;
  region_t                 r_region;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_iom;
  logic                    r_is_read;
  logic [c_CNT_W-1:0]      r_cnt;
  logic                    r_ready;
  logic                    r_oe;
  logic                    r_wr;
  logic                    r_cs_mem0;
  logic                    r_cs_mem1;
  logic                    r_cs_io;
  logic                    r_bus_err;

  logic [ADDR_WIDTH-1:0]   w_latch_addr;
  region_t                 w_region;
  logic                    w_hit;
  logic [c_CNT_W-1:0]      w_wait;
  logic                    w_strobe_low;
  logic                    w_drive_ad;
  logic                    w_drive_data;

  // IO space is 16 bits wide, so the top nibble is forced to zero
  assign w_latch_addr = IOM ? {{(ADDR_WIDTH-16){1'b0}}, A_HI[7:0], AD}
                            : {A_HI, AD};

  bus_addr_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM0_BASE  (MEM0_BASE),
    .MEM0_SIZE  (MEM0_SIZE),
    .MEM1_BASE  (MEM1_BASE),
    .MEM1_SIZE  (MEM1_SIZE),
    .IO_BASE    (IO_BASE),
    .IO_SIZE    (IO_SIZE)
  ) u_decoder (
    .i_addr   (w_latch_addr),
    .i_iom    (IOM),
    .o_region (w_region)
  );

  assign w_hit        = (r_region != NONE);
  assign w_wait       = r_iom ? c_IO_WAIT : c_MEM_WAIT;
  assign w_strobe_low = r_is_read ? !RD_n : !WR_n;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_region  <= NONE;
      r_addr    <= '0;
      r_iom     <= 1'b0;
      r_is_read <= 1'b0;
      r_cnt     <= '0;
      r_ready   <= 1'b1;
      r_oe      <= 1'b1;
      r_wr      <= 1'b1;
      r_cs_mem0 <= 1'b0;
      r_cs_mem1 <= 1'b0;
      r_cs_io   <= 1'b0;
      r_bus_err <= 1'b0;
    end else if (ALE) begin
      // A new address phase always wins; outside IDLE it aborts the current cycle
      r_bus_err <= r_bus_err | (r_state != IDLE);
      r_addr    <= w_latch_addr;
      r_iom     <= IOM;
      r_region  <= w_region;
      r_cs_mem0 <= (w_region == MEM0);
      r_cs_mem1 <= (w_region == MEM1);
      r_cs_io   <= (w_region == IO);
      r_ready   <= 1'b1;
      r_oe      <= 1'b1;
      r_wr      <= 1'b1;
      r_state   <= ADDR;
    end else begin
      case (r_state)
        IDLE: r_state <= IDLE;
        ADDR: begin
          if (!RD_n && !WR_n) begin
            r_bus_err <= 1'b1;
            r_cs_mem0 <= 1'b0;
            r_cs_mem1 <= 1'b0;
            r_cs_io   <= 1'b0;
            r_region  <= NONE;
            r_state   <= IDLE;
          end else if (!RD_n || !WR_n) begin
            r_is_read <= !RD_n;
            r_cnt     <= w_wait;
            r_oe      <= !(w_hit && !RD_n);
            r_wr      <= !(w_hit && !WR_n);
            if (w_wait != '0) begin
              r_ready <= !w_hit;
              r_state <= WAIT;
            end else begin
              r_state <= XFER;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == c_CNT_W'(1)) begin
            r_ready <= 1'b1;
            r_state <= XFER;
          end
        end
        XFER: begin
          if (!w_strobe_low) begin
            r_oe      <= 1'b1;
            r_wr      <= 1'b1;
            r_cs_mem0 <= 1'b0;
            r_cs_mem1 <= 1'b0;
            r_cs_io   <= 1'b0;
            r_region  <= NONE;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read and write enables are mutually exclusive through r_is_read
  assign w_drive_ad   = r_is_read && w_hit && !r_oe;
  assign w_drive_data = !r_is_read && w_hit && ((r_state == WAIT) || (r_state == XFER));

  assign AD   = w_drive_ad   ? Data : {DATA_WIDTH{1'bz}};
  assign Data = w_drive_data ? AD   : {DATA_WIDTH{1'bz}};

  assign READY   = r_ready;
  assign Address = r_addr;
  assign CS_MEM0 = r_cs_mem0;
  assign CS_MEM1 = r_cs_mem1;
  assign CS_IO   = r_cs_io;
  assign OE      = r_oe;
  assign WR      = r_wr;
  assign BUS_ERR = r_bus_err;

endmodule
`default_nettype wire
